// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_sequencer_pkg;

    localparam int LINE_BITS_DEF = 5;
    localparam int WORD_BITS_DEF = 32;
    localparam int CNT_BITS      = 6;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INC     = 3'd1,
        S_SETTLE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_SHIFT   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/fetch_sequencer_word_deserialiser.sv
// Serial-in, LSB-first word assembler with clear and accepted-bit counter.
// Latency: one bit per enabled edge; tc is combinational on the edge taking the last bit.
// Backpressure: en low holds both the partial word and the count.
module fetch_sequencer_word_deserialiser
    import fetch_sequencer_pkg::*;
#(
    parameter int WORD_BITS = WORD_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 bit_in,
    output logic [WORD_BITS-1:0] word,
    output logic                 tc
);

    logic [WORD_BITS-1:0] word_q, word_d;
    logic [CNT_BITS-1:0]  count_q, count_d;

    // Clear wins over shift; new bits enter at the MSB so the first bit ends at bit 0.
    always_comb begin
        word_d  = word_q;
        count_d = count_q;
        if (clr) begin
            word_d  = '0;
            count_d = '0;
        end else if (en) begin
            word_d  = {bit_in, word_q[WORD_BITS-1:1]};
            count_d = count_q + CNT_BITS'(1);
        end
    end

    // Shift register and counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            count_q <= '0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

    assign tc   = en && !clr && (count_q == CNT_BITS'(WORD_BITS - 1));
    assign word = word_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch: step PC, capture bus address, read store line serially, hand word to control.
// Latency: WORD_VALID rises 35 edges after START with STORE_RDY high; +1 per STORE_RDY-low SHIFT cycle.
// Backpressure: STORE_RDY stalls shifting; WORD held in DONE until WORD_ACK.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int LINE_BITS = LINE_BITS_DEF,
    parameter int WORD_BITS = WORD_BITS_DEF
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic [WORD_BITS-1:0] BUS,
    output logic                 PC_OE_n,
    output logic                 PC_STEP,
    input  logic                 STORE_RDY,
    input  logic                 STORE_BIT,
    output logic [LINE_BITS-1:0] LINE,
    output logic                 LINE_VALID,
    output logic [WORD_BITS-1:0] WORD,
    output logic                 WORD_VALID,
    input  logic                 WORD_ACK,
    output logic                 BUSY
);

    state_t               state_q, state_d;
    logic                 pc_oe_n_q, pc_oe_n_d;
    logic                 pc_step_q, pc_step_d;
    logic                 line_valid_q, line_valid_d;
    logic                 word_valid_q, word_valid_d;
    logic                 busy_q, busy_d;
    logic [LINE_BITS-1:0] line_q, line_d;
    logic                 shift_en;
    logic                 shift_clr;
    logic                 shift_tc;
    logic                 bus_hi_unused;

    // Only the low address bits select a store line; the PC wraps silently.
    assign bus_hi_unused = ^BUS[WORD_BITS-1:LINE_BITS];

    assign shift_en  = (state_q == S_SHIFT) && STORE_RDY;
    assign shift_clr = (state_q == S_CAPTURE);

    fetch_sequencer_word_deserialiser #(
        .WORD_BITS (WORD_BITS)
    ) u_deser (
        .clk    (CLK),
        .rst    (RESET),
        .clr    (shift_clr),
        .en     (shift_en),
        .bit_in (STORE_BIT),
        .word   (WORD),
        .tc     (shift_tc)
    );

    // State register plus registered Moore outputs; reset also releases the PC bus driver.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            pc_oe_n_q    <= 1'b1;
            pc_step_q    <= 1'b0;
            line_valid_q <= 1'b0;
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_oe_n_q    <= pc_oe_n_d;
            pc_step_q    <= pc_step_d;
            line_valid_q <= line_valid_d;
            word_valid_q <= word_valid_d;
            busy_q       <= busy_d;
            line_q       <= line_d;
        end
    end

    // Next-state: START only honoured from IDLE or on the acknowledging edge in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (START) state_d = S_INC;
            S_INC:     state_d = S_SETTLE;
            S_SETTLE:  state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_SHIFT;
            S_SHIFT:   if (shift_tc) state_d = S_DONE;
            S_DONE:    if (WORD_ACK) state_d = START ? S_INC : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so every output flop matches the state it enters.
    always_comb begin
        pc_step_d    = (state_d == S_INC);
        pc_oe_n_d    = !((state_d == S_SETTLE) || (state_d == S_CAPTURE));
        line_valid_d = (state_d == S_SHIFT);
        word_valid_d = (state_d == S_DONE);
        busy_d       = (state_d != S_IDLE);
        line_d       = line_q;
        if (state_q == S_CAPTURE) begin
            line_d = BUS[LINE_BITS-1:0];
        end
    end

    assign PC_OE_n    = pc_oe_n_q;
    assign PC_STEP    = pc_step_q;
    assign LINE       = line_q;
    assign LINE_VALID = line_valid_q;
    assign WORD_VALID = word_valid_q;
    assign BUSY       = busy_q;

endmodule
